// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO between the UART receiver and the host-side
// consumer. Exposes qualified per-cycle strobes wr_fire/rd_fire for the status
// controller downstream. Read data is registered with one cycle of latency.
// Optional build macro UART_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags
// with an err_clr input; without it, illegal requests are silently ignored.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
`ifdef UART_FIFO_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  wr_fire,
    output logic                  rd_fire
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle;
    // an empty FIFO never forwards a same-cycle write to the read side.
    assign rd_fire = rd_en & ~empty_q;
    assign wr_fire = wr_en & (~full_q | rd_en);

    // Next-state occupancy and the status flags derived from it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        count_d = count_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d        = (count_d == DEPTH_C);
        empty_d       = (count_d == '0);
        almost_full_d = (count_d >= AF_C);
    end

    // Storage array: written on an accepted write only.
    // NOTE: the memory is deliberately not reset; stale contents are unreachable
    // because pointers and count are cleared, and a reset here would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy, flags and the registered read port.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almost_full_q <= almost_full_d;
            dout_valid_q  <= rd_fire;
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                dout_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = almost_full_q;
    assign count       = count_q;

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags; err_clr wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en & full_q & ~rd_en) begin
                overflow_q <= 1'b1;
            end
            if (rd_en & empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue scoreboard holds the bytes the
// bench expects to be buffered; its size is the expected occupancy.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full, empty, almost_full;
    logic [AW:0]   count;
    logic          wr_fire, rd_fire;
`ifdef UART_FIFO_ERR_FLAGS_EN
    logic          err_clr = 1'b0;
    logic          overflow, underflow;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
`endif

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_valid = 1'b0;
    logic          got_wr_fire, got_rd_fire;

    uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .din(din),
        .rd_en(rd_en),
        .dout(dout),
        .dout_valid(dout_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .count(count),
`ifdef UART_FIFO_ERR_FLAGS_EN
        .err_clr(err_clr),
        .overflow(overflow),
        .underflow(underflow),
`endif
        .wr_fire(wr_fire),
        .rd_fire(rd_fire)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive at negedge, check strobes before the edge,
    // update the scoreboard, then check registered outputs after the edge.
    task automatic step(input string tag, input logic wr, input logic [DW-1:0] d,
                        input logic rd);
        logic e_wf, e_rf;
        int   n;
        @(negedge clk);
        wr_en = wr;
        din   = d;
        rd_en = rd;
        #1;
        n    = sb.size();
        e_rf = rd && (n > 0);
        e_wf = wr && ((n < DEPTH) || rd);
        got_wr_fire = wr_fire;
        got_rd_fire = rd_fire;
        vectors++;
        if (wr_fire !== e_wf) begin
            miscompares++;
            $display("FAIL %s wr_fire: got %b expected %b", tag, wr_fire, e_wf);
        end
        vectors++;
        if (rd_fire !== e_rf) begin
            miscompares++;
            $display("FAIL %s rd_fire: got %b expected %b", tag, rd_fire, e_rf);
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        if (err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && (n == DEPTH) && !rd) m_ovf = 1'b1;
            if (rd && (n == 0)) m_unf = 1'b1;
        end
`endif
        if (e_rf) exp_dout = sb.pop_front();
        if (e_wf) sb.push_back(d);
        exp_valid = e_rf;
        @(posedge clk);
        #1;
        vectors++;
        if (count !== (AW+1)'(sb.size())) begin
            miscompares++;
            $display("FAIL %s count: got %0d expected %0d", tag, count, sb.size());
        end
        vectors++;
        if ({empty, full, almost_full} !== {sb.size() == 0, sb.size() == DEPTH, sb.size() >= AF}) begin
            miscompares++;
            $display("FAIL %s flags(e,f,af): got %b%b%b expected %b%b%b", tag, empty, full,
                     almost_full, sb.size() == 0, sb.size() == DEPTH, sb.size() >= AF);
        end
        vectors++;
        if (dout_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL %s dout_valid: got %b expected %b", tag, dout_valid, exp_valid);
        end
        vectors++;
        if (dout !== exp_dout) begin
            miscompares++;
            $display("FAIL %s dout: got %h expected %h", tag, dout, exp_dout);
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        vectors++;
        if ({overflow, underflow} !== {m_ovf, m_unf}) begin
            miscompares++;
            $display("FAIL %s err(ovf,unf): got %b%b expected %b%b", tag, overflow, underflow,
                     m_ovf, m_unf);
        end
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
`ifdef UART_FIFO_ERR_FLAGS_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({empty, full, almost_full, dout_valid, wr_fire, rd_fire} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset flags(e,f,af,v,wf,rf): got %b%b%b%b%b%b expected 100000",
                     empty, full, almost_full, dout_valid, wr_fire, rd_fire);
        end
        vectors++;
        if (count !== 5'd0 || dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset count/dout: got %0d/%h expected 0/00", count, dout);
        end
        step("reset_idle", 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_basic();
        logic [AW:0] exp_cnt[6] = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0};
        logic [DW-1:0] bytes[3] = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step("basic_wr", 1'b1, bytes[i], 1'b0);
            else       step("basic_rd", 1'b0, 8'h00, 1'b1);
            vectors++;
            if (count !== exp_cnt[i]) begin
                miscompares++;
                $display("FAIL basic count[%0d]: got %0d expected %0d", i, count, exp_cnt[i]);
            end
            if (i >= 3) begin
                vectors++;
                if (dout !== bytes[i-3] || dout_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic read[%0d]: got %h/%b expected %h/1", i-3, dout,
                             dout_valid, bytes[i-3]);
                end
            end
        end
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL basic empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step("fill_wr", 1'b1, 8'(i), 1'b0);
            vectors++;
            if (almost_full !== (i + 1 >= 12) || full !== (i + 1 == 16)) begin
                miscompares++;
                $display("FAIL fill af/full at count %0d: got %b/%b expected %b/%b", i + 1,
                         almost_full, full, i + 1 >= 12, i + 1 == 16);
            end
        end
        step("fill_over", 1'b1, 8'hFF, 1'b0);
        vectors++;
        if (got_wr_fire !== 1'b0 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL fill overflow write: got wr_fire=%b count=%0d expected 0/16",
                     got_wr_fire, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step("drain_rd", 1'b0, 8'h00, 1'b1);
            vectors++;
            if (dout !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain order[%0d]: got %h expected %h", i, dout, 8'(i));
            end
        end
        step("drain_empty_rd", 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) step("full_fill", 1'b1, 8'(8'h10 + i), 1'b0);
        step("full_rw", 1'b1, 8'hAA, 1'b1);
        vectors++;
        if (got_wr_fire !== 1'b1 || got_rd_fire !== 1'b1 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL full_rw: got wf=%b rf=%b count=%0d expected 1/1/16", got_wr_fire,
                     got_rd_fire, count);
        end
        for (int i = 0; i < DEPTH; i++) step("full_drain", 1'b0, 8'h00, 1'b1);
        vectors++;
        if (dout !== 8'hAA) begin
            miscompares++;
            $display("FAIL full_rw last word: got %h expected aa", dout);
        end
    endtask

    task automatic test_empty_rw();
        step("empty_rw", 1'b1, 8'h55, 1'b1);
        vectors++;
        if (got_wr_fire !== 1'b1 || got_rd_fire !== 1'b0 || dout_valid !== 1'b0 ||
            count !== 5'd1) begin
            miscompares++;
            $display("FAIL empty_rw: got wf=%b rf=%b v=%b count=%0d expected 1/0/0/1",
                     got_wr_fire, got_rd_fire, dout_valid, count);
        end
        step("empty_rw_rd", 1'b0, 8'h00, 1'b1);
        vectors++;
        if (dout !== 8'h55) begin
            miscompares++;
            $display("FAIL empty_rw read: got %h expected 55", dout);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step("mid_fill", 1'b1, 8'(8'hC0 + i), 1'b0);
        apply_reset();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: got count=%0d empty=%b dout=%h expected 0/1/00", count,
                     empty, dout);
        end
        step("mid_after", 1'b1, 8'h99, 1'b0);
        step("mid_after_rd", 1'b0, 8'h00, 1'b1);
    endtask

`ifdef UART_FIFO_ERR_FLAGS_EN
    task automatic test_err_flags();
        step("unf_set", 1'b0, 8'h00, 1'b1);
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow set: got %b expected 1", underflow);
        end
        step("unf_hold", 1'b0, 8'h00, 1'b0);
        err_clr = 1'b1;
        step("unf_clr_pri", 1'b0, 8'h00, 1'b1);
        err_clr = 1'b0;
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow clear: got %b expected 0", underflow);
        end
        for (int i = 0; i < DEPTH; i++) step("ovf_fill", 1'b1, 8'(i), 1'b0);
        step("ovf_set", 1'b1, 8'hEE, 1'b0);
        step("ovf_hold", 1'b0, 8'h00, 1'b1);
        err_clr = 1'b1;
        step("ovf_clr", 1'b0, 8'h00, 1'b0);
        err_clr = 1'b0;
        apply_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_reset_mid();
`ifdef UART_FIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
